iq_mixer_accumulator: RTL and testbench

- Downstream consumer of the CORDIC sin/cos generator in the sensor signal path.
- Multiplies each signed ADC sample by the matching SIN and COS values and accumulates the products over a programmable window.
- At the end of each window it emits I = Σ ADC·COS and Q = Σ ADC·SIN with a one-cycle valid strobe.
- Feeds the phase/magnitude estimation stage.

---
 rtl/iq_mixer_accumulator_pkg.sv | 22 ++
 rtl/iq_mixer_accumulator_if.sv | 33 +++
 rtl/iq_mixer_accumulator_mac_lane.sv | 58 +++++
 rtl/iq_mixer_accumulator.sv | 123 ++++++++++++
 tb/tb_iq_mixer_accumulator.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/iq_mixer_accumulator_pkg.sv
// iq_mixer_pkg: shared types and constants for the IQ mixer/accumulator.
//   sample_tag_t     - per-sample pipeline tag {valid, first, last}
//   calc_acc_bits()  - accumulator width that cannot overflow for a full window
//   IQ_MIXER_LATENCY - CE cycles from a sample being presented to its result strobe
package iq_mixer_pkg;

  localparam int IQ_MIXER_LATENCY = 3;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } sample_tag_t;

  // Product needs DATA_BITS+ADC_BITS, and summing up to 2^WINDOW_BITS of them
  // adds WINDOW_BITS more.
  function automatic int calc_acc_bits(input int data_bits, input int adc_bits,
                                       input int window_bits);
    return data_bits + adc_bits + window_bits;
  endfunction

endpackage

// File: rtl/iq_mixer_accumulator_if.sv
// iq_mixer_accumulator_if: sample/result bundle of the IQ mixer/accumulator.
//   master modport: drives ENABLE, WINDOW_LEN, ADC_IN, SIN, COS; sees I_OUT, Q_OUT, OUT_VALID
//   slave  modport: the accumulator itself
// Handshake: there is no ready. A sample is taken on every CE=1 edge, and it counts
// when ENABLE=1. OUT_VALID is a one-CE-cycle strobe with no backpressure. I_OUT/Q_OUT
// are valid while it is high, and they hold until the next strobe.
interface iq_mixer_accumulator_if
  import iq_mixer_pkg::*;
#(
  parameter int DATA_BITS   = 16,
  parameter int ADC_BITS    = 12,
  parameter int WINDOW_BITS = 10,
  parameter int ACC_BITS    = calc_acc_bits(DATA_BITS, ADC_BITS, WINDOW_BITS)
);
  logic                       ENABLE;
  logic [WINDOW_BITS-1:0]     WINDOW_LEN;
  logic [ADC_BITS-1:0]        ADC_IN;
  logic signed [DATA_BITS-1:0] SIN;
  logic signed [DATA_BITS-1:0] COS;
  logic signed [ACC_BITS-1:0] I_OUT;
  logic signed [ACC_BITS-1:0] Q_OUT;
  logic                       OUT_VALID;

  modport master (
    output ENABLE, WINDOW_LEN, ADC_IN, SIN, COS,
    input  I_OUT, Q_OUT, OUT_VALID
  );

  modport slave (
    input  ENABLE, WINDOW_LEN, ADC_IN, SIN, COS,
    output I_OUT, Q_OUT, OUT_VALID
  );
endinterface

// File: rtl/iq_mixer_accumulator_mac_lane.sv
// iq_mac_lane: one signed multiply-accumulate lane (S2 product, S3 accumulate/output).
//   CLK, RESET (async, active high), CE - clock, reset, clock enable
//   a, b    - S1-registered signed operands
//   tag     - tag of the sample whose product currently sits in the S2 register
//   sum_out - accumulated sum of the last completed window
module iq_mac_lane
  import iq_mixer_pkg::*;
#(
  parameter int A_BITS   = 12,
  parameter int B_BITS   = 16,
  parameter int ACC_BITS = 38
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       CE,
  input  logic signed [A_BITS-1:0]   a,
  input  logic signed [B_BITS-1:0]   b,
  input  sample_tag_t                tag,
  output logic signed [ACC_BITS-1:0] sum_out
);
  localparam int P_BITS = A_BITS + B_BITS;

  logic signed [P_BITS-1:0]   a_ext;
  logic signed [P_BITS-1:0]   b_ext;
  logic signed [P_BITS-1:0]   prod_d;
  logic signed [P_BITS-1:0]   prod_q;
  logic signed [ACC_BITS-1:0] prod_ext;
  logic signed [ACC_BITS-1:0] acc_q;
  logic signed [ACC_BITS-1:0] acc_next;

  // Both operands are widened to the product width, so the multiply is done at
  // the width of its result. The true product always fits in P_BITS.
  assign a_ext    = {{B_BITS{a[A_BITS-1]}}, a};
  assign b_ext    = {{A_BITS{b[B_BITS-1]}}, b};
  assign prod_d   = a_ext * b_ext;
  assign prod_ext = {{(ACC_BITS-P_BITS){prod_q[P_BITS-1]}}, prod_q};

  // A FIRST sample starts a new sum, and this covers a window of one as well.
  // Otherwise the product is added to the running sum.
  always_comb begin
    acc_next = acc_q + prod_ext;
    if (tag.first) acc_next = prod_ext;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      prod_q  <= '0;
      acc_q   <= '0;
      sum_out <= '0;
    end else if (CE) begin
      prod_q <= prod_d;
      if (tag.valid) begin
        acc_q <= acc_next;
        if (tag.last) sum_out <= acc_next;
      end
    end
  end
endmodule

// File: rtl/iq_mixer_accumulator.sv
// iq_mixer_accumulator: multiplies signed ADC samples by SIN/COS and sums the
// products over a programmable window. I = sum ADC*COS, Q = sum ADC*SIN.
//   CLK   - clock
//   RESET - asynchronous, active-high reset
//   CE    - clock enable; every register advances only on CE=1 edges
//   bus   - iq_mixer_accumulator_if.slave (ENABLE, WINDOW_LEN, ADC_IN, SIN, COS in;
//           I_OUT, Q_OUT, OUT_VALID out)
// Pipeline: S1 input/tag registers, S2 products, S3 accumulate and output.
// Build option IQ_MIXER_ADC_UNSIGNED_EN: ADC_IN is offset binary. It is converted
// to two's complement by inverting its MSB before S1.
module iq_mixer_accumulator
  import iq_mixer_pkg::*;
#(
  parameter int DATA_BITS   = 16,
  parameter int ADC_BITS    = 12,
  parameter int WINDOW_BITS = 10,
  parameter int ACC_BITS    = calc_acc_bits(DATA_BITS, ADC_BITS, WINDOW_BITS)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              CE,
  iq_mixer_accumulator_if.slave bus
);
  localparam logic [WINDOW_BITS-1:0] CNT_ONE = 1;
  localparam logic [WINDOW_BITS:0]   LEN_ONE = 1;
  localparam logic [WINDOW_BITS:0]   LEN_MAX = {1'b1, {WINDOW_BITS{1'b0}}};

  logic signed [ADC_BITS-1:0]  adc_signed;
  logic signed [ADC_BITS-1:0]  adc_s1;
  logic signed [DATA_BITS-1:0] sin_s1;
  logic signed [DATA_BITS-1:0] cos_s1;
  sample_tag_t                 tag_s1;
  sample_tag_t                 tag_s2;
  logic                        out_valid_q;

  logic [WINDOW_BITS-1:0] win_cnt_q;
  logic [WINDOW_BITS-1:0] win_len_q;
  logic [WINDOW_BITS-1:0] len_sel;
  logic [WINDOW_BITS:0]   len_eff;
  logic                   is_first;
  logic                   is_last;

`ifdef IQ_MIXER_ADC_UNSIGNED_EN
  // Offset binary to two's complement: midscale maps to zero.
  assign adc_signed = {~bus.ADC_IN[ADC_BITS-1], bus.ADC_IN[ADC_BITS-2:0]};
`else
  assign adc_signed = bus.ADC_IN;
`endif

  // The first sample of a window uses WINDOW_LEN directly, so a new length (and
  // a window of one) takes effect at once. Later samples use the copy latched on
  // that first sample. A length of 0 means the full 2^WINDOW_BITS.
  always_comb begin
    is_first = (win_cnt_q == '0);
    len_sel  = win_len_q;
    if (is_first) len_sel = bus.WINDOW_LEN;
    len_eff = {1'b0, len_sel};
    if (len_sel == '0) len_eff = LEN_MAX;
    is_last = ({1'b0, win_cnt_q} == (len_eff - LEN_ONE));
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      adc_s1      <= '0;
      sin_s1      <= '0;
      cos_s1      <= '0;
      tag_s1      <= '0;
      tag_s2      <= '0;
      out_valid_q <= 1'b0;
      win_cnt_q   <= '0;
      win_len_q   <= '0;
    end else if (CE) begin
      adc_s1       <= adc_signed;
      sin_s1       <= bus.SIN;
      cos_s1       <= bus.COS;
      tag_s1.valid <= bus.ENABLE;
      tag_s1.first <= bus.ENABLE & is_first;
      tag_s1.last  <= bus.ENABLE & is_last;
      tag_s2       <= tag_s1;
      // Set on the same edge that S3 writes the final sums.
      out_valid_q  <= tag_s2.valid & tag_s2.last;
      if (!bus.ENABLE) begin
        // Drop the partial window. Samples already in S1/S2 were tagged without
        // LAST, so they finish without producing a strobe.
        win_cnt_q <= '0;
      end else begin
        if (is_first) win_len_q <= bus.WINDOW_LEN;
        win_cnt_q <= is_last ? '0 : win_cnt_q + CNT_ONE;
      end
    end
  end

  // The strobe is held while CE=0 and is shown only during a CE=1 cycle.
  assign bus.OUT_VALID = out_valid_q & CE;

  iq_mac_lane #(
    .A_BITS  (ADC_BITS),
    .B_BITS  (DATA_BITS),
    .ACC_BITS(ACC_BITS)
  ) u_lane_i (
    .CLK    (CLK),
    .RESET  (RESET),
    .CE     (CE),
    .a      (adc_s1),
    .b      (cos_s1),
    .tag    (tag_s2),
    .sum_out(bus.I_OUT)
  );

  iq_mac_lane #(
    .A_BITS  (ADC_BITS),
    .B_BITS  (DATA_BITS),
    .ACC_BITS(ACC_BITS)
  ) u_lane_q (
    .CLK    (CLK),
    .RESET  (RESET),
    .CE     (CE),
    .a      (adc_s1),
    .b      (sin_s1),
    .tag    (tag_s2),
    .sum_out(bus.Q_OUT)
  );
endmodule

// File: tb/tb_iq_mixer_accumulator.sv
// tb_iq_mixer_accumulator: directed bench for iq_mixer_accumulator.
// The stimulus pushes the hand-computed {I, Q} and the expected strobe cycle into
// queues. A negedge monitor pops and compares them on every OUT_VALID.
module tb_iq_mixer_accumulator;
  localparam int DB   = 16;
  localparam int AB   = 12;
  localparam int WB   = 10;
  localparam int ACCB = DB + AB + WB;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RESET;
  logic CE;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc++;

  iq_mixer_accumulator_if #(.DATA_BITS(DB), .ADC_BITS(AB), .WINDOW_BITS(WB), .ACC_BITS(ACCB)) bus ();

  iq_mixer_accumulator #(.DATA_BITS(DB), .ADC_BITS(AB), .WINDOW_BITS(WB), .ACC_BITS(ACCB)) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .CE   (CE),
    .bus  (bus)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [2*ACCB-1:0] exp_q[$];
  int                exp_cyc_q[$];

  task automatic chk(input string name, input logic signed [ACCB-1:0] act,
                     input logic signed [ACCB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic push_exp(input longint i_val, input longint q_val, input int at_cyc);
    logic [ACCB-1:0] i_bits;
    logic [ACCB-1:0] q_bits;
    i_bits = i_val[ACCB-1:0];
    q_bits = q_val[ACCB-1:0];
    exp_q.push_back({i_bits, q_bits});
    exp_cyc_q.push_back(at_cyc);
  endtask

  always @(negedge CLK) begin
    logic [2*ACCB-1:0]      e;
    logic signed [ACCB-1:0] ei;
    logic signed [ACCB-1:0] eq;
    int                     ec;
    if (!RESET && bus.OUT_VALID === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse cyc=%0d got I=%0d Q=%0d expected no strobe",
                 cyc, bus.I_OUT, bus.Q_OUT);
      end else begin
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        ei = e[2*ACCB-1:ACCB];
        eq = e[ACCB-1:0];
        chk("i_out", bus.I_OUT, ei);
        chk("q_out", bus.Q_OUT, eq);
        if (ec >= 0) chk("pulse_cycle", ACCB'(cyc), ACCB'(ec));
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [AB-1:0] adc_raw(input int s);
    logic [AB-1:0] r;
    r = s[AB-1:0];
`ifdef IQ_MIXER_ADC_UNSIGNED_EN
    r[AB-1] = ~r[AB-1];
`endif
    return r;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input bit en, input int adc, input int sn, input int cs);
    bus.ENABLE = en;
    bus.ADC_IN = adc_raw(adc);
    bus.SIN    = sn[DB-1:0];
    bus.COS    = cs[DB-1:0];
  endtask

  task automatic drain();
    drive(0, 0, 0, 0);
    repeat (6) tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [AB-1:0] raw;
    RESET = 1'b1;
    CE    = 1'b1;
    bus.WINDOW_LEN = 10'd4;
    drive(0, 0, 0, 0);
    repeat (3) tick();
    chk("reset_i_out", bus.I_OUT, '0);
    chk("reset_q_out", bus.Q_OUT, '0);
    chk("reset_out_valid", ACCB'(bus.OUT_VALID), '0);
    RESET = 1'b0;
    tick();

    // Constant window of 4: a strobe every 4 cycles, 3 cycles after each 4th sample.
    bus.WINDOW_LEN = 10'd4;
    for (int k = 0; k < 12; k++) begin
      drive(1, 1000, 0, 32767);
      if (k % 4 == 3) push_exp(131068000, 0, cyc + 3);
      tick();
    end
    drain();

    // Negative extremes over a full 1024-sample window (WINDOW_LEN=0).
    bus.WINDOW_LEN = 10'd0;
    for (int k = 0; k < 1024; k++) begin
      drive(1, -2048, -32768, 32767);
      if (k == 1023) push_exp(-64'sd68717379584, 64'sd68719476736, cyc + 3);
      tick();
    end
    drain();

    // ENABLE drops after 5 of 8 samples. Only the following full window reports.
    bus.WINDOW_LEN = 10'd8;
    for (int k = 0; k < 5; k++) begin
      drive(1, 1, 1, 1);
      tick();
    end
    drive(0, 1, 1, 1);
    repeat (2) tick();
    for (int k = 0; k < 8; k++) begin
      drive(1, 1, 1, 1);
      if (k == 7) push_exp(8, 8, cyc + 3);
      tick();
    end
    drain();

    // CE alternating. Junk with ENABLE=1 is driven while CE=0 and must not be taken.
    // I = 3*(10+20+30+40) = 300, Q = -2*100 = -200.
    bus.WINDOW_LEN = 10'd4;
    for (int k = 0; k < 4; k++) begin
      CE = 1'b1;
      drive(1, 10 * (k + 1), -2, 3);
      if (k == 3) push_exp(300, -200, -1);
      tick();
      CE = 1'b0;
      drive(1, 999, 77, 55);
      tick();
    end
    for (int k = 0; k < 8; k++) begin
      CE = 1'b1;
      drive(0, 0, 0, 0);
      tick();
      CE = 1'b0;
      tick();
    end
    CE = 1'b1;
    drain();

    // Async reset in the middle of a window, asserted between edges.
    for (int k = 0; k < 4; k++) begin
      drive(1, 5, 11, 7);
      if (k == 3) push_exp(140, 220, cyc + 3);
      tick();
    end
    drain();
    for (int k = 0; k < 3; k++) begin
      drive(1, 5, 11, 7);
      tick();
    end
    #2;
    RESET = 1'b1;
    #1;
    chk("async_reset_i_out", bus.I_OUT, '0);
    chk("async_reset_q_out", bus.Q_OUT, '0);
    chk("async_reset_out_valid", ACCB'(bus.OUT_VALID), '0);
    tick();
    drive(0, 0, 0, 0);
    tick();
    RESET = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(1, 2, 4, 3);
      if (k == 3) push_exp(24, 32, cyc + 3);
      tick();
    end
    drain();

    // Raw ADC code 2548 is 500 in offset binary and -1548 in two's complement.
    bus.WINDOW_LEN = 10'd2;
    raw = 12'd2548;
    for (int k = 0; k < 2; k++) begin
      bus.ENABLE = 1'b1;
      bus.ADC_IN = raw;
      bus.SIN    = '0;
      bus.COS    = 16'sd100;
`ifdef IQ_MIXER_ADC_UNSIGNED_EN
      if (k == 1) push_exp(100000, 0, cyc + 3);
`else
      if (k == 1) push_exp(-309600, 0, cyc + 3);
`endif
      tick();
    end
    drain();

    // Every expected strobe must have been seen.
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_pulses got %0d outstanding expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
